// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RISC-V immediate extension feeding a small FIFO of results.
// The immediate is decoded once at the input. On accept, the result is stored
// with its tag and error flag. The head entry is presented on the out_* port.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [24:0]              in_imm,
    input  logic [2:0]               in_src,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_imm,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_err,
    output logic [7:0]               err_cnt,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int ENT_W = XLEN + TAG_W + 1;
    localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);

    localparam logic [2:0] SRC_I  = 3'b000;
    localparam logic [2:0] SRC_S  = 3'b001;
    localparam logic [2:0] SRC_B  = 3'b010;
    localparam logic [2:0] SRC_J  = 3'b011;
    localparam logic [2:0] SRC_U  = 3'b100;
    localparam logic [2:0] SRC_SH = 3'b101;
    localparam logic [2:0] SRC_Z  = 3'b110;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    logic [XLEN-1:0]  imm_ext;
    logic             imm_err;
    logic [ENT_W-1:0] wr_ent;
    logic [ENT_W-1:0] head;
    logic             accept, pop;

    // Immediate extension. The sign is filled first, then the low field is overlaid.
    always_comb begin
        imm_ext = '0;
        imm_err = 1'b0;
        case (in_src)
            SRC_I: begin
                imm_ext        = {XLEN{in_imm[24]}};
                imm_ext[11:0]  = in_imm[24:13];
            end
            SRC_S: begin
                imm_ext        = {XLEN{in_imm[24]}};
                imm_ext[11:0]  = {in_imm[24:18], in_imm[4:0]};
            end
            SRC_B: begin
                imm_ext        = {XLEN{in_imm[24]}};
                imm_ext[12:0]  = {in_imm[24], in_imm[0], in_imm[23:18], in_imm[4:1], 1'b0};
            end
            SRC_J: begin
                imm_ext        = {XLEN{in_imm[24]}};
                imm_ext[20:0]  = {in_imm[24], in_imm[12:5], in_imm[13], in_imm[23:14], 1'b0};
            end
            SRC_U: begin
                imm_ext        = {XLEN{in_imm[24]}};
                imm_ext[31:0]  = {in_imm[24:5], 12'b0};
            end
            SRC_SH: begin
                imm_ext[4:0]   = in_imm[17:13];
                if (XLEN == 64) imm_ext[5] = in_imm[18];
            end
            SRC_Z: begin
                imm_ext[4:0]   = in_imm[12:8];
            end
            default: begin
                imm_err        = 1'b1;
            end
        endcase
    end

    // Handshakes and next-state logic for the pointers, occupancy and error counter.
    // in_ready depends only on occupancy. A pop in the same cycle does not open a slot for the input.
    always_comb begin
        in_ready  = (occ_q != FULL_CNT);
        out_valid = (occ_q != '0);
        accept    = in_valid && in_ready;
        pop       = out_valid && out_ready;
        wr_ent    = {imm_err, in_tag, imm_ext};

        wr_ptr_d  = accept ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop    ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        occ_d = occ_q;
        case ({accept, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        err_cnt_d = err_cnt_q;
        if (accept && imm_err && (err_cnt_q != 8'hFF))
            err_cnt_d = err_cnt_q + 8'd1;
    end

    // Queue storage. Only the slot under the write pointer changes on accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (accept) begin
            mem_q[wr_ptr_q] <= wr_ent;
        end
    end

    // Pointer, occupancy and error counter state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Head presentation. Outputs are forced to zero while the queue is empty.
    always_comb begin
        head    = mem_q[rd_ptr_q];
        out_imm = out_valid ? head[XLEN-1:0]          : '0;
        out_tag = out_valid ? head[XLEN +: TAG_W]     : '0;
        out_err = out_valid ? head[ENT_W-1]           : 1'b0;
    end

    assign err_cnt   = err_cnt_q;
    assign occupancy = occ_q;

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, immediate output width; legal values 32 and 64.
REQ-002 Parameter DEPTH, default 2, output queue entries; power of two, 2..16.
REQ-003 Parameter TAG_W, default 5, width of sideband tag carried with each request.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  queue can accept a request.
REQ-008 in_imm  input  25  instruction bits [31:7]; bit 0 = instr[7].
REQ-009 in_src  input  3  format select: 000 I, 001 S, 010 B, 011 J, 100 U, 101 SH (shamt), 110 Z (CSR zimm), 111 reserved.
REQ-010 in_tag  input  TAG_W  sideband tag, returned unchanged.
REQ-011 out_valid  output  1  head entry valid.
REQ-012 out_ready  input  1  consumer accepts head entry.
REQ-013 out_imm  output  XLEN  extended immediate of head entry.
REQ-014 out_tag  output  TAG_W  tag of head entry.
REQ-015 out_err  output  1  head entry had reserved in_src.
REQ-016 err_cnt  output  8  count of reserved-format requests accepted.
REQ-017 occupancy  output  $clog2(DEPTH)+1  entries currently held.

Function
REQ-018 Request accepted on a cycle where in_valid && in_ready; response popped where out_valid && out_ready.
REQ-019 Extension computed combinationally at input, result written to queue on accept; no second computation.
REQ-020 sext() = sign-extend to XLEN from MSB shown; zext() = zero-extend to XLEN.
REQ-021 I: sext(in_imm[24:13]).
REQ-022 S: sext({in_imm[24:18], in_imm[4:0]}).
REQ-023 B: sext({in_imm[24], in_imm[0], in_imm[23:18], in_imm[4:1], 1'b0}).
REQ-024 J: sext({in_imm[24], in_imm[12:5], in_imm[13], in_imm[23:14], 1'b0}).
REQ-025 U: sext({in_imm[24:5], 12'b0}); for XLEN=32 upper bits are exactly in_imm[24:5].
REQ-026 SH: zext(in_imm[17:13]) when XLEN=32; zext(in_imm[18:13]) when XLEN=64.
REQ-027 Z: zext(in_imm[12:8]).
REQ-028 Reserved (111): stored out_imm = 0, out_err = 1; all other formats store out_err = 0.
REQ-029 Queue strictly FIFO; circular read/write pointers wrap modulo DEPTH.
REQ-030 in_ready = (occupancy < DEPTH) || out_ready-pop in same cycle not permitted: in_ready depends only on occupancy (no combinational out_ready->in_ready path).
REQ-031 Empty: out_valid = 0, out_imm/out_tag/out_err = 0; pop ignored.
REQ-032 Full: in_ready = 0; in_valid ignored, no state change from input side.
REQ-033 Simultaneous accept and pop with 0 < occupancy < DEPTH: occupancy unchanged, both pointers advance.
REQ-034 Minimum latency one cycle: request accepted at edge N visible on out_valid after edge N.
REQ-035 err_cnt increments by 1 per accepted reserved request; saturates at 255, never wraps.
REQ-036 Accepting a request while in_valid held and in_ready=1 over consecutive cycles sustains one accept per cycle.

Reset
REQ-037 reset_n low asynchronously clears pointers, occupancy=0, err_cnt=0, out_valid=0, out_imm/out_tag/out_err=0; in_ready=1 while reset_n low.
REQ-038 Reset mid-operation discards all queued entries; no entry emitted after reset deasserts until a new accept.
REQ-039 Reset deassertion synchronised by integrator; block tolerates release on any edge-aligned cycle.

Verification
REQ-040 XLEN=32: in_src=000, in_imm[24:13]=12'hFFF -> out_imm=32'hFFFF_FFFF one cycle after accept, out_err=0.
REQ-041 XLEN=32: B format, in_imm[24]=1, in_imm[0]=0, others 0 -> out_imm=32'hFFFF_F000; J with only in_imm[13]=1 -> 32'h0000_0800.
REQ-042 XLEN=64: U format in_imm[24:5]=20'h80000 -> out_imm=64'hFFFF_FFFF_8000_0000; SH in_imm[18:13]=6'h3F -> 64'h3F.
REQ-043 DEPTH=2, out_ready=0: accept 2 requests -> in_ready=0, occupancy=2; third in_valid ignored; then out_ready=1 -> tags emerge in order.
REQ-044 Send 257 reserved requests -> err_cnt=255, each out_err=1, out_imm=0.
REQ-045 Fill queue to 1, assert reset_n low mid-cycle -> out_valid=0, occupancy=0 immediately, nothing emitted after release.
